cgra_tcdm_responder: RTL
========================

CGRA_TCDM_RESPONDER -- requirements
Module: cgra_tcdm_responder

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, meaning the number of master ports (matches CGRA MP).
REQ-002 SHALL have parameter N_BANKS, default 4 (power of two), meaning the number of word-interleaved SRAM banks.
REQ-003 SHALL have parameter BANK_DEPTH, default 256 (power of two), meaning the words per bank.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, and parameter DATA_WIDTH, default 32, meaning the bus address width and the bus data width.
REQ-005 SHALL have port clk_i, input, width 1: the single clock.
REQ-006 SHALL have port rst_i, input, width 1: reset, synchronous and active-high.
REQ-007 SHALL have port tcdm_req_i, input, width N_PORTS: per-port request.
REQ-008 SHALL have port tcdm_add_i, input, width ADDR_WIDTH x N_PORTS: byte address per port.
REQ-009 SHALL have port tcdm_wen_i, input, width N_PORTS: 1 = write, 0 = read.
REQ-010 SHALL have port tcdm_be_i, input, width 4 x N_PORTS: byte enables per port.
REQ-011 SHALL have port tcdm_wdata_i, input, width DATA_WIDTH x N_PORTS: write data per port.
REQ-012 SHALL have port tcdm_gnt_o, output, width N_PORTS: grant per port.
REQ-013 SHALL have port tcdm_rdata_o, output, width DATA_WIDTH x N_PORTS: read data per port.
REQ-014 SHALL have port tcdm_r_valid_o, output, width N_PORTS: response valid per port.
REQ-015 SHALL have port conflict_cnt_o, output, width 32: saturating count of bank-conflict cycles.

Function
REQ-016 Bank select SHALL be add[2 +: log2(N_BANKS)], row SHALL be the next log2(BANK_DEPTH) bits; all other address bits SHALL be ignored, so out-of-range addresses alias (wrap).
REQ-017 tcdm_gnt_o SHALL be combinational in the request cycle; each bank SHALL grant at most one port per cycle.
REQ-018 Each bank SHALL use a round-robin arbiter over its requesting ports; after a grant, the priority pointer SHALL move to the granted port + 1 modulo N_PORTS; with no grant, the pointer SHALL hold.
REQ-019 Request transfer SHALL occur on req & gnt at a rising edge; a granted write SHALL update only the bytes whose be bit is 1.
REQ-020 tcdm_r_valid_o[p] SHALL assert exactly one cycle after each transfer on port p (reads and writes), for one cycle.
REQ-021 For reads, tcdm_rdata_o[p] SHALL carry the addressed word, valid only with r_valid; for writes, rdata SHALL be 0.
REQ-022 A port SHALL be able to issue back-to-back transfers every cycle; the response pipeline SHALL have no backpressure.
REQ-023 A read and write to the same word in consecutive cycles SHALL return the already-written data (write completes before the next read).
REQ-024 A cycle SHALL count as a conflict when any requesting port is not granted; conflict_cnt_o SHALL increment by 1 per such cycle and saturate at 0xFFFFFFFF.
REQ-025 Ports without req SHALL never receive gnt.

Reset
REQ-026 While rst_i is high: tcdm_gnt_o SHALL be 0 (combinationally masked), and no memory write SHALL occur.
REQ-027 On a clock edge with rst_i high: r_valid SHALL be 0, rdata SHALL be 0, all arbiter pointers SHALL be 0, conflict_cnt_o SHALL be 0, and the stall LFSR SHALL be set to its seed.
REQ-028 Reset asserted mid-transfer SHALL drop pending responses (no r_valid the cycle after reset); memory contents SHALL NOT be reset.

Configuration
REQ-029 Macro CGRA_TCDM_STALL_INJ_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1) advancing every cycle SHALL suppress all grants in any cycle where LFSR[1:0] == 2'b00; suppressed cycles SHALL count as conflicts if any req is high.
REQ-030 Macro CGRA_TCDM_STALL_INJ_EN undefined: there SHALL be no LFSR and no grant suppression; grants SHALL depend only on arbitration.

Verification
REQ-031 Port 0 writes 0xDEADBEEF to 0x10 with be=4'hF, then reads 0x10 -> gnt same cycle, r_valid the next cycle each, read rdata = 0xDEADBEEF.
REQ-032 Word 0x20 holds 0x11223344; write 0xAABBCCDD with be=4'b0101, then read -> 0x11BB33DD.
REQ-033 All 4 ports read bank 0 (addresses 0x00, 0x10, 0x20, 0x30) and hold req -> grants in order p0, p1, p2, p3 on consecutive cycles; conflict_cnt_o = 3.
REQ-034 4 ports access addresses 0x0, 0x4, 0x8, 0xC (distinct banks) -> all granted in one cycle; conflict_cnt_o unchanged.
REQ-035 rst_i asserted in the cycle after a grant -> no r_valid appears; after reset, a read of the previously written word returns the preserved data.
REQ-036 With CGRA_TCDM_STALL_INJ_EN, port 0 requests continuously for 64 cycles -> grant pattern matches the LFSR reference model; every transfer gets r_valid exactly one cycle later.

Source files
------------

// File: rtl/cgra_tcdm_responder.sv
// -----------------------------------------------------------------------------
// cgra_tcdm_responder
//
// Multi-port TCDM slave for a CGRA. N_PORTS master ports share N_BANKS
// word-interleaved single-port SRAM banks. Each bank has its own round-robin
// arbiter, so ports that target different banks are all served in the same
// cycle. Grants are combinational in the request cycle. Responses (r_valid
// plus read data) appear exactly one cycle after each transfer. Responses are
// never back-pressured.
//
// Address map: bank = add[2 +: log2(N_BANKS)], row = next log2(BANK_DEPTH)
// bits. All other address bits are ignored, so out-of-range addresses alias.
//
// Ports:
//   clk_i           single clock
//   rst_i           synchronous, active-high reset
//   tcdm_req_i      per-port request
//   tcdm_add_i      per-port byte address
//   tcdm_wen_i      per-port 1 = write, 0 = read
//   tcdm_be_i       per-port byte enables
//   tcdm_wdata_i    per-port write data
//   tcdm_gnt_o      per-port grant (combinational)
//   tcdm_rdata_o    per-port read data (0 for write responses)
//   tcdm_r_valid_o  per-port response valid, one cycle after the transfer
//   conflict_cnt_o  saturating count of cycles in which a request went ungranted
//
// Optional feature macro: CGRA_TCDM_STALL_INJ_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1)
//   advances every cycle and suppresses all grants whenever LFSR[1:0] == 2'b00.
//   When undefined, grants depend only on arbitration.
// -----------------------------------------------------------------------------
module cgra_tcdm_responder #(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned N_BANKS    = 4,
    parameter int unsigned BANK_DEPTH = 256,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [N_PORTS-1:0]                    tcdm_req_i,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]    tcdm_add_i,
    input  logic [N_PORTS-1:0]                    tcdm_wen_i,
    input  logic [N_PORTS-1:0][3:0]               tcdm_be_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]    tcdm_wdata_i,
    output logic [N_PORTS-1:0]                    tcdm_gnt_o,
    output logic [N_PORTS-1:0][DATA_WIDTH-1:0]    tcdm_rdata_o,
    output logic [N_PORTS-1:0]                    tcdm_r_valid_o,
    output logic [31:0]                           conflict_cnt_o
);

    localparam int unsigned BANK_BITS = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int unsigned ROW_BITS  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int unsigned PTR_BITS  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef logic [BANK_BITS-1:0] bank_t;
    typedef logic [ROW_BITS-1:0]  row_t;
    typedef logic [PTR_BITS-1:0]  ptr_t;

    // Port index reached by stepping offs places from base, wrapping at N_PORTS.
    function automatic ptr_t rr_port(input ptr_t base, input int unsigned offs);
        int unsigned idx;
        idx = 32'(base) + offs;
        if (idx >= N_PORTS) idx = idx - N_PORTS;
        return ptr_t'(idx);
    endfunction

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    bank_t [N_PORTS-1:0] port_bank;
    row_t  [N_PORTS-1:0] port_row;
    logic                unused_addr_bits;

    // NOTE: every signal driven from always_comb gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    always_comb begin
        port_bank = '0;
        port_row  = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            port_bank[p] = tcdm_add_i[p][2 +: BANK_BITS];
            port_row[p]  = tcdm_add_i[p][2 + BANK_BITS +: ROW_BITS];
        end
    end

    // High address bits alias by design; fold them into a sink.
    assign unused_addr_bits = ^tcdm_add_i;

    // ------------------------------------------------------------------------
    // Stall injection
    // ------------------------------------------------------------------------
    logic stall;

`ifdef CGRA_TCDM_STALL_INJ_EN
    logic [15:0] lfsr_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Per-bank round-robin arbitration
    // ------------------------------------------------------------------------
    ptr_t [N_BANKS-1:0] ptr_q;
    ptr_t [N_BANKS-1:0] bank_win;
    logic [N_BANKS-1:0] bank_gnt;
    logic [N_PORTS-1:0] gnt;
    logic [N_PORTS-1:0] xfer;

    always_comb begin
        gnt      = '0;
        bank_win = '0;
        bank_gnt = '0;
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            // Search starts at the bank's pointer; first requester wins.
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if (!bank_gnt[b] && tcdm_req_i[rr_port(ptr_q[b], i)] &&
                    port_bank[rr_port(ptr_q[b], i)] == bank_t'(b)) begin
                    bank_gnt[b]                = 1'b1;
                    bank_win[b]                = rr_port(ptr_q[b], i);
                    gnt[rr_port(ptr_q[b], i)]  = 1'b1;
                end
            end
        end
        // Masking here also keeps pointers frozen and blocks memory writes.
        if (rst_i || stall) begin
            gnt      = '0;
            bank_gnt = '0;
        end
    end

    assign tcdm_gnt_o = gnt;
    assign xfer       = tcdm_req_i & gnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            for (int unsigned b = 0; b < N_BANKS; b++) begin
                if (bank_gnt[b]) begin
                    ptr_q[b] <= (bank_win[b] == ptr_t'(N_PORTS - 1)) ? '0
                                                                     : bank_win[b] + ptr_t'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bank storage
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [N_BANKS][BANK_DEPTH];

    // NOTE: the SRAM array has no reset on purpose: contents survive reset and
    // the array maps onto real memory macros. Writes are blocked during reset
    // because gnt is masked.
    always_ff @(posedge clk_i) begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (xfer[p] && tcdm_wen_i[p]) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (tcdm_be_i[p][k]) begin
                        mem_q[port_bank[p]][port_row[p]][8*k +: 8] <= tcdm_wdata_i[p][8*k +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response pipeline (one stage, no backpressure)
    // ------------------------------------------------------------------------
    logic [N_PORTS-1:0]                 rvalid_q;
    logic [N_PORTS-1:0][DATA_WIDTH-1:0] rdata_q;

    // A write in cycle k lands at that edge, so a read granted in k+1 already
    // sees it. Two ports never touch one bank in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                rvalid_q[p] <= xfer[p];
                rdata_q[p]  <= (xfer[p] && !tcdm_wen_i[p]) ? mem_q[port_bank[p]][port_row[p]]
                                                           : '0;
            end
        end
    end

    // A response still in flight when reset rises is dropped immediately.
    always_comb begin
        tcdm_r_valid_o = rvalid_q & ~{N_PORTS{rst_i}};
        tcdm_rdata_o   = rst_i ? '0 : rdata_q;
    end

    // ------------------------------------------------------------------------
    // Conflict counter
    // ------------------------------------------------------------------------
    logic [31:0] conflict_cnt_q;
    logic        conflict;

    assign conflict = |(tcdm_req_i & ~gnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_q <= '0;
        end else if (conflict && conflict_cnt_q != '1) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;

endmodule
